// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-port memory between the fetch stage (read-only)
// and the memory stage (read/write). Data wins ties unless fetch has lost
// STARVE_MAX consecutive contested arbitrations.
//
// state  | meaning
// IDLE   | arbitrate between if_req_i and d_req_i, latch winner's request
// ACCESS | drive memory from latched request for MEM_LAT cycles
// DONE   | one-cycle ack to the granted requester, no arbitration
`timescale 1ns/1ps
module mem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                if_req_i,
  input  logic [ADDR_W-1:0]   if_addr_i,
  output logic                if_ack_o,
  output logic [DATA_W-1:0]   if_rdata_o,
  input  logic                d_req_i,
  input  logic                d_we_i,
  input  logic [ADDR_W-1:0]   d_addr_i,
  input  logic [DATA_W-1:0]   d_wdata_i,
  input  logic [DATA_W/8-1:0] d_be_i,
  output logic                d_ack_o,
  output logic [DATA_W-1:0]   d_rdata_o,
  output logic [ADDR_W-1:0]   mem_addr_o,
  output logic                mem_re_o,
  output logic                mem_we_o,
  output logic [DATA_W-1:0]   mem_wdata_o,
  output logic [DATA_W/8-1:0] mem_be_o,
  input  logic [DATA_W-1:0]   mem_rdata_i,
  output logic                busy_o
);

  localparam int BE_W  = DATA_W / 8;
  localparam int LAT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam int CNT_W = $clog2(STARVE_MAX + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic              gnt_data_q, gnt_data_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [BE_W-1:0]   be_q, be_d;
  logic [LAT_W-1:0]  lat_q, lat_d;
  logic [CNT_W-1:0]  starve_q, starve_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
  logic              fetch_win;
  logic              starved;

  assign starved = (starve_q == CNT_W'(STARVE_MAX));

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      gnt_data_q <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      be_q       <= '0;
      lat_q      <= '0;
      starve_q   <= '0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
    end else begin
      state_q    <= state_d;
      gnt_data_q <= gnt_data_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      be_q       <= be_d;
      lat_q      <= lat_d;
      starve_q   <= starve_d;
      if_rdata_q <= if_rdata_d;
      d_rdata_q  <= d_rdata_d;
    end
  end

  // Next-state, arbitration and memory/ack output decode.
  always_comb begin
    state_d     = state_q;
    gnt_data_d  = gnt_data_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    be_d        = be_q;
    lat_d       = lat_q;
    starve_d    = starve_q;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;
    fetch_win   = 1'b0;
    if_ack_o    = 1'b0;
    d_ack_o     = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    mem_be_o    = '0;
    mem_re_o    = 1'b0;
    mem_we_o    = 1'b0;

    case (state_q)
      IDLE: begin
        if (if_req_i || d_req_i) begin
          fetch_win = if_req_i && (!d_req_i || starved);
          if (fetch_win) begin
            gnt_data_d = 1'b0;
            we_d       = 1'b0;
            addr_d     = if_addr_i;
            wdata_d    = '0;
            be_d       = '1;
            starve_d   = '0;
          end else begin
            gnt_data_d = 1'b1;
            we_d       = d_we_i;
            addr_d     = d_addr_i;
            wdata_d    = d_wdata_i;
            be_d       = d_be_i;
            // Only a contested data win counts against fetch.
            if (if_req_i && !starved) starve_d = starve_q + CNT_W'(1);
          end
          lat_d   = '0;
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        mem_addr_o  = addr_q;
        mem_wdata_o = wdata_q;
        mem_be_o    = be_q;
        mem_re_o    = !we_q;
        // A single write strobe per access, regardless of MEM_LAT.
        mem_we_o    = we_q && (lat_q == '0);
        lat_d       = lat_q + LAT_W'(1);
        if (lat_q == LAT_W'(MEM_LAT - 1)) begin
          if (!we_q) begin
            if (gnt_data_q) d_rdata_d  = mem_rdata_i;
            else            if_rdata_d = mem_rdata_i;
          end
          state_d = DONE;
        end
      end
      DONE: begin
        if_ack_o = !gnt_data_q;
        d_ack_o  = gnt_data_q;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign if_rdata_o = if_rdata_q;
  assign d_rdata_o  = d_rdata_q;
  assign busy_o     = (state_q != IDLE);

endmodule
